alu_share_arb: RTL and testbench
================================

# alu_share_arb

Two-requester arbiter and sequencer for the single shared 32-bit ALU in the RISC-V pipeline.
- Requesters: port 0 is the EX-stage issue path; port 1 is the auxiliary engine (CSR/debug address calculation).
- Each cycle it grants at most one requester round-robin, drives the ALU operand/opcode bus combinationally, captures the ALU result in a response register, and holds it until the consumer accepts it.
- Throughput is one operation per cycle when the consumer is always ready.

## Interface
Parameters:
- DW, 32, ALU operand/result width
- OPW, 5, ALU opcode width (matches the ALUOp encoding)
- CW, 16, width of the per-requester grant counters

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  reset, synchronous, active-low
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid
- req0_op  in  OPW  requester 0 ALU opcode
- req0_a, req0_b, req0_pc  in  DW each  requester 0 operands and PC
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_pc  same as requester 0, for requester 1
- alu_op  out  OPW  opcode to the shared ALU
- alu_a, alu_b, alu_pc  out  DW each  operands to the shared ALU
- alu_c  in  DW  ALU result (combinational from alu_* outputs)
- alu_zero  in  1  ALU zero flag
- resp_valid  out  1  response register holds a result
- resp_ready  in  1  consumer accepts the response
- resp_id  out  1  requester that issued the held result
- resp_c  out  DW  held result
- resp_zero  out  1  held zero flag
- gnt_cnt0, gnt_cnt1  out  CW each  saturating count of grants to requester 0 / 1

## Operation
- FSM states:
  - EMPTY: no response held.
  - FULL: response held, resp_valid=1.
- Accept window: `can_accept = (state==EMPTY) | resp_ready`.
- Grant selection, only when can_accept:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester the pointer `rr` selects (rr=0 selects requester 0).
  - reqN_ready = can_accept & grant==N. It is combinational and is never high for both requesters.
- On a grant, in the same cycle:
  - alu_op/alu_a/alu_b/alu_pc = the granted requester's fields.
  - At the clock edge: resp_c<=alu_c, resp_zero<=alu_zero, resp_id<=N, state<=FULL.
  - rr <= ~N.
  - gnt_cntN increments, saturating at all-ones.
- With no grant, alu_op, alu_a, alu_b and alu_pc are driven to all zeros.
- FULL with resp_ready=1 and no grant: state<=EMPTY.
- FULL with resp_ready=1 and a grant: stays FULL with the new result (back-to-back).
- FULL with resp_ready=0: resp_* hold stable, both reqN_ready=0, rr unchanged.
- rr changes only on a grant. A lone requester winning still flips rr.
- Width rules:
  - All operands pass through unmodified.
  - The arbiter does no arithmetic on the data.
  - Counters are unsigned CW-bit.
- Reset (rstn=0 at a clock edge) has priority over everything, including mid-hold and simultaneous handshakes. It sets:
  - state=EMPTY, rr=0, resp_valid=0, resp_id=0, resp_c=0, resp_zero=0, gnt_cnt0=gnt_cnt1=0.
- During reset, reqN_ready are forced 0 and alu_* are forced 0.

## Timing
- Request to resp_valid latency: 1 cycle. The handshake at edge k makes resp_valid high after edge k.
- The ALU path is combinational within the grant cycle. The critical path is reqN_valid → grant mux → ALU → resp_c register.
- resp_valid and resp_* are registered outputs. reqN_ready and alu_* are combinational.
- A requester must hold valid and its fields stable until it sees ready. The arbiter may switch its grant between cycles while neither requester has been accepted.
- Sustained throughput: 1 op/cycle with resp_ready tied high. Two always-valid requesters alternate 0,1,0,1,…
- Fairness: a continuously valid requester waits at most 1 grant to the other requester.

## Test plan
- Reset, then the first request.
  - Stimulus: assert rstn=0 for 2 cycles with both reqN_valid=1; release rstn; req0 op=add, a=5, b=7; resp_ready=1.
  - Required response: during reset, no ready, all outputs 0. After release, req0_ready=1 in the first cycle, and the next cycle shows resp_valid=1, resp_c=12, resp_id=0, gnt_cnt0=1.
- Both requesters valid for 6 cycles, resp_ready=1.
  - Required response: grants alternate 0,1,0,1,0,1 and resp_id follows one cycle later.
  - req1 op=sub, a=3, b=5 → resp_c=0xFFFFFFFE, resp_zero=0.
- Backpressure.
  - Stimulus: resp_ready=0 for 3 cycles after a result of 0; then resp_ready=1.
  - Required response: resp_valid=1, resp_zero=1 and resp_c=0 hold for all 3 cycles, and both readies stay 0. When resp_ready=1, the pending req1 is accepted the same cycle.
- Drain without a new request.
  - Stimulus: FULL, resp_ready=1, no valids.
  - Required response: the next cycle has resp_valid=0, and alu_op=0, alu_a=0.
- Counter saturation.
  - Stimulus: CW=4; 20 back-to-back req0-only grants.
  - Required response: gnt_cnt0 stops at 15 and gnt_cnt1 stays 0.
- Reset mid-hold.
  - Stimulus: FULL with resp_c=0x1234 and resp_ready=0; pulse rstn=0 for 1 cycle.
  - Required response: resp_valid=0, resp_c=0, rr=0 and counters 0 on the next cycle.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Request, shared-ALU and response bus of the two-port ALU arbiter.
// The arbiter uses the slave modport; requesters, the ALU and the consumer
// sit on the master side.
interface alu_share_arb_if #(
  parameter int DW  = 32,
  parameter int OPW = 5,
  parameter int CW  = 16
);
  logic           req0_valid;
  logic           req0_ready;
  logic [OPW-1:0] req0_op;
  logic [DW-1:0]  req0_a;
  logic [DW-1:0]  req0_b;
  logic [DW-1:0]  req0_pc;

  logic           req1_valid;
  logic           req1_ready;
  logic [OPW-1:0] req1_op;
  logic [DW-1:0]  req1_a;
  logic [DW-1:0]  req1_b;
  logic [DW-1:0]  req1_pc;

  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_pc;
  logic [DW-1:0]  alu_c;
  logic           alu_zero;

  logic           resp_valid;
  logic           resp_ready;
  logic           resp_id;
  logic [DW-1:0]  resp_c;
  logic           resp_zero;

  logic [CW-1:0]  gnt_cnt0;
  logic [CW-1:0]  gnt_cnt1;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_pc,
    input  req1_valid, req1_op, req1_a, req1_b, req1_pc,
    input  alu_c, alu_zero, resp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b, alu_pc,
    output resp_valid, resp_id, resp_c, resp_zero,
    output gnt_cnt0, gnt_cnt1
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_pc,
    output req1_valid, req1_op, req1_a, req1_b, req1_pc,
    output alu_c, alu_zero, resp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b, alu_pc,
    input  resp_valid, resp_id, resp_c, resp_zero,
    input  gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer for the single shared ALU. One requester is
// granted per cycle, its fields drive the ALU combinationally, and the ALU
// result is captured into a one-entry response register held until the
// consumer takes it. A ready consumer allows one operation per cycle.
module alu_share_arb #(
  parameter int DW  = 32,
  parameter int OPW = 5,
  parameter int CW  = 16
) (
  input logic            clk,
  input logic            rstn,
  alu_share_arb_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic          rr_q;
  logic          can_accept;
  logic          gnt_vld;
  logic          gnt_id;

  logic [DW-1:0] resp_c_p1;
  logic          resp_zero_p1;
  logic          resp_id_p1;
  logic [CW-1:0] cnt0_q;
  logic [CW-1:0] cnt1_q;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] one;
    one = {{(CW-1){1'b0}}, 1'b1};
    return (&v) ? v : v + one;
  endfunction

  // Grant selection: a lone requester wins outright, a tie goes to rr.
  // Gating with rstn keeps both readies low while reset is held.
  always_comb begin
    can_accept = rstn & ((state_q == EMPTY) | bus.resp_ready);
    gnt_vld    = 1'b0;
    gnt_id     = 1'b0;
    if (can_accept) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_q;
      end else if (bus.req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = gnt_vld & ~gnt_id;
  assign bus.req1_ready = gnt_vld &  gnt_id;

  // ALU operand mux: the granted requester's fields, zeros when idle.
  always_comb begin
    bus.alu_op = '0;
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_pc = '0;
    if (gnt_vld) begin
      if (gnt_id) begin
        bus.alu_op = bus.req1_op;
        bus.alu_a  = bus.req1_a;
        bus.alu_b  = bus.req1_b;
        bus.alu_pc = bus.req1_pc;
      end else begin
        bus.alu_op = bus.req0_op;
        bus.alu_a  = bus.req0_a;
        bus.alu_b  = bus.req0_b;
        bus.alu_pc = bus.req0_pc;
      end
    end
  end

  // Next state: a grant always (re)fills the register; an accepted result
  // with nothing behind it drains it.
  always_comb begin
    state_d = state_q;
    if (gnt_vld) begin
      state_d = FULL;
    end else if ((state_q == FULL) && bus.resp_ready) begin
      state_d = EMPTY;
    end
  end

  // ---- stage p1: response register, rr pointer and grant counters ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= EMPTY;
      rr_q         <= 1'b0;
      resp_c_p1    <= '0;
      resp_zero_p1 <= 1'b0;
      resp_id_p1   <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_vld) begin
        resp_c_p1    <= bus.alu_c;
        resp_zero_p1 <= bus.alu_zero;
        resp_id_p1   <= gnt_id;
        rr_q         <= ~gnt_id;
        if (gnt_id) begin
          cnt1_q <= sat_inc(cnt1_q);
        end else begin
          cnt0_q <= sat_inc(cnt0_q);
        end
      end
    end
  end

  assign bus.resp_valid = (state_q == FULL);
  assign bus.resp_c     = resp_c_p1;
  assign bus.resp_zero  = resp_zero_p1;
  assign bus.resp_id    = resp_id_p1;
  assign bus.gnt_cnt0   = cnt0_q;
  assign bus.gnt_cnt1   = cnt1_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the arbiter. The bench also
// plays the role of the shared ALU.
module tb_alu_share_arb;
  localparam int DW  = 32;
  localparam int OPW = 5;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  alu_share_arb_if #(.DW(DW), .OPW(OPW), .CW(CW)) bus ();

  alu_share_arb #(.DW(DW), .OPW(OPW), .CW(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Shared ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, otherwise pc+a.
  function automatic logic [DW-1:0] alu_fn(input logic [OPW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b,
                                           input logic [DW-1:0] pc);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a ^ b;
      default: return pc + a;
    endcase
  endfunction

  assign bus.alu_c    = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_pc);
  assign bus.alu_zero = (bus.alu_c == '0);

  int n_cmp = 0;
  int n_err = 0;

  // Transaction-level model state.
  bit            m_full = 0;
  bit            m_rr = 0;
  bit            m_id = 0;
  logic [DW-1:0] m_c = '0;
  bit            m_zero = 0;
  int            m_cnt0 = 0;
  int            m_cnt1 = 0;
  // Per-cycle expectation derived before the edge.
  bit            e_gnt;
  bit            e_id;
  logic [DW-1:0] e_c;
  logic [OPW-1:0] e_op;
  logic [DW-1:0] e_a, e_b, e_pc;

  task automatic model_pre();
    bit can;
    can   = rstn && (!m_full || bus.resp_ready);
    e_gnt = 0;
    e_id  = 0;
    if (can && bus.req0_valid && bus.req1_valid) begin e_gnt = 1; e_id = m_rr; end
    else if (can && bus.req0_valid) begin e_gnt = 1; e_id = 0; end
    else if (can && bus.req1_valid) begin e_gnt = 1; e_id = 1; end
    e_op = '0; e_a = '0; e_b = '0; e_pc = '0;
    if (e_gnt && e_id) begin
      e_op = bus.req1_op; e_a = bus.req1_a; e_b = bus.req1_b; e_pc = bus.req1_pc;
    end else if (e_gnt) begin
      e_op = bus.req0_op; e_a = bus.req0_a; e_b = bus.req0_b; e_pc = bus.req0_pc;
    end
    e_c = alu_fn(e_op, e_a, e_b, e_pc);
  endtask

  // Advance one clock and apply the model's transition for it.
  task automatic step();
    bit rdy;
    model_pre();
    rdy = bus.resp_ready;
    @(posedge clk);
    if (!rstn) begin
      m_full = 0; m_rr = 0; m_id = 0; m_c = '0; m_zero = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else if (e_gnt) begin
      m_full = 1;
      m_id   = e_id;
      m_c    = e_c;
      m_zero = (e_c == '0);
      m_rr   = !e_id;
      if (e_id) m_cnt1 = (m_cnt1 < CMAX) ? m_cnt1 + 1 : CMAX;
      else      m_cnt0 = (m_cnt0 < CMAX) ? m_cnt0 + 1 : CMAX;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    #1;
  endtask

  task automatic set_req0(input bit v, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] pc);
    bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_pc = pc;
  endtask

  task automatic set_req1(input bit v, input logic [OPW-1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] pc);
    bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_pc = pc;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.resp_ready = 1'b1;
    set_req0(1, 5'd0, 32'd5, 32'd7, 32'h100);
    set_req1(1, 5'd1, 32'd3, 32'd5, 32'h200);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_err++; $display("FAIL reset_ready: got %b%b want 00", bus.req0_ready, bus.req1_ready);
      end
      n_cmp++;
      if (bus.alu_op !== '0 || bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_pc !== '0) begin
        n_err++; $display("FAIL reset_alu: got op=%0h a=%0h want 0", bus.alu_op, bus.alu_a);
      end
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b0 || bus.resp_c !== '0 || bus.resp_id !== 1'b0 ||
          bus.resp_zero !== 1'b0 || bus.gnt_cnt0 !== '0 || bus.gnt_cnt1 !== '0) begin
        n_err++; $display("FAIL reset_regs: got v=%b c=%0h id=%b z=%b c0=%0d c1=%0d want all 0",
                          bus.resp_valid, bus.resp_c, bus.resp_id, bus.resp_zero,
                          bus.gnt_cnt0, bus.gnt_cnt1);
      end
    end
    rstn = 1'b1;
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL first_ready: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    n_cmp++;
    if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
      n_err++; $display("FAIL first_alu: got a=%0d b=%0d want 5 7", bus.alu_a, bus.alu_b);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_c !== 32'd12 || bus.resp_id !== 1'b0 ||
        bus.gnt_cnt0 !== 4'd1) begin
      n_err++; $display("FAIL first_resp: got v=%b c=%0d id=%b c0=%0d want 1 12 0 1",
                        bus.resp_valid, bus.resp_c, bus.resp_id, bus.gnt_cnt0);
    end
  endtask

  task automatic test_alternate();
    bit prev_g;
    bit g;
    prev_g = 1'b0;   // the reset test ended with a grant to requester 0
    for (int i = 0; i < 6; i++) begin
      #1;
      g = bus.req1_ready;
      n_cmp++;
      if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1 || g === prev_g) begin
        n_err++; $display("FAIL alt_grant%0d: got %b%b want grant to %0d", i,
                          bus.req0_ready, bus.req1_ready, !prev_g);
      end
      step();
      n_cmp++;
      if (bus.resp_id !== !prev_g) begin
        n_err++; $display("FAIL alt_id%0d: got %b want %b", i, bus.resp_id, !prev_g);
      end
      n_cmp++;
      if (!prev_g && (bus.resp_c !== 32'hFFFF_FFFE || bus.resp_zero !== 1'b0)) begin
        n_err++; $display("FAIL alt_sub%0d: got c=%h z=%b want fffffffe 0", i, bus.resp_c, bus.resp_zero);
      end else if (prev_g && bus.resp_c !== 32'd12) begin
        n_err++; $display("FAIL alt_add%0d: got c=%0d want 12", i, bus.resp_c);
      end
      prev_g = !prev_g;
    end
  endtask

  task automatic test_backpressure();
    set_req1(0, 5'd0, '0, '0, '0);
    set_req0(1, 5'd1, 32'd9, 32'd9, 32'h0);
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_c !== '0 || bus.resp_zero !== 1'b1) begin
      n_err++; $display("FAIL bp_zero: got v=%b c=%0h z=%b want 1 0 1", bus.resp_valid, bus.resp_c, bus.resp_zero);
    end
    bus.resp_ready = 1'b0;
    set_req0(0, 5'd0, '0, '0, '0);
    set_req1(1, 5'd1, 32'd3, 32'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_ready%0d: got %b%b want 00", i, bus.req0_ready, bus.req1_ready);
      end
      step();
      n_cmp++;
      if (bus.resp_valid !== 1'b1 || bus.resp_c !== '0 || bus.resp_zero !== 1'b1) begin
        n_err++; $display("FAIL bp_hold%0d: got v=%b c=%0h z=%b want 1 0 1", i,
                          bus.resp_valid, bus.resp_c, bus.resp_zero);
      end
    end
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.req1_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_release: got req1_ready=%b want 1", bus.req1_ready);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_c !== 32'hFFFF_FFFE) begin
      n_err++; $display("FAIL bp_next: got v=%b id=%b c=%h want 1 1 fffffffe",
                        bus.resp_valid, bus.resp_id, bus.resp_c);
    end
  endtask

  task automatic test_drain();
    set_req0(0, 5'd3, 32'hAA, 32'h55, 32'h1);
    set_req1(0, 5'd3, 32'hBB, 32'h55, 32'h1);
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.alu_op !== '0 || bus.alu_a !== '0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL drain_alu: got op=%0h a=%0h rdy=%b%b want 0 0 00",
                        bus.alu_op, bus.alu_a, bus.req0_ready, bus.req1_ready);
    end
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_valid: got %b want 0", bus.resp_valid);
    end
  endtask

  task automatic test_saturation();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_req0(1, 5'd0, 32'(i), 32'd1, 32'h0);
      #1;
      step();
      n_cmp++;
      if (bus.gnt_cnt0 !== CW'((i + 1 > CMAX) ? CMAX : i + 1) || bus.gnt_cnt1 !== '0) begin
        n_err++; $display("FAIL sat_cnt%0d: got c0=%0d c1=%0d want %0d 0", i,
                          bus.gnt_cnt0, bus.gnt_cnt1, (i + 1 > CMAX) ? CMAX : i + 1);
      end
    end
    n_cmp++;
    if (bus.gnt_cnt0 !== 4'd15 || bus.resp_c !== 32'd20) begin
      n_err++; $display("FAIL sat_final: got c0=%0d c=%0d want 15 20", bus.gnt_cnt0, bus.resp_c);
    end
  endtask

  task automatic test_reset_mid_hold();
    set_req0(1, 5'd0, 32'h1000, 32'h0234, 32'h0);
    bus.resp_ready = 1'b1;
    #1;
    step();
    bus.resp_ready = 1'b0;
    set_req0(0, 5'd0, '0, '0, '0);
    #1;
    step();
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_c !== 32'h1234) begin
      n_err++; $display("FAIL hold_pre: got v=%b c=%h want 1 1234", bus.resp_valid, bus.resp_c);
    end
    rstn = 1'b0;
    bus.resp_ready = 1'b1;
    set_req0(1, 5'd2, 32'hF0F0, 32'hFF00, 32'h0);
    set_req1(1, 5'd4, 32'h1, 32'h1, 32'h0);
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.alu_a !== '0) begin
      n_err++; $display("FAIL hold_rst_comb: got rdy=%b%b a=%h want 00 0",
                        bus.req0_ready, bus.req1_ready, bus.alu_a);
    end
    step();
    rstn = 1'b1;
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.resp_c !== '0 || bus.gnt_cnt0 !== '0 || bus.gnt_cnt1 !== '0) begin
      n_err++; $display("FAIL hold_rst: got v=%b c=%h c0=%0d c1=%0d want 0 0 0 0",
                        bus.resp_valid, bus.resp_c, bus.gnt_cnt0, bus.gnt_cnt1);
    end
    #1;
    n_cmp++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
      n_err++; $display("FAIL hold_rr: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    step();
    n_cmp++;
    if (bus.resp_id !== 1'b0 || bus.resp_c !== 32'h0000_F000) begin
      n_err++; $display("FAIL hold_after: got id=%b c=%h want 0 0000f000", bus.resp_id, bus.resp_c);
    end
  endtask

  task automatic test_random();
    bit acc0, acc1;
    acc0 = 1; acc1 = 1;
    for (int i = 0; i < 400; i++) begin
      if (acc0 || !bus.req0_valid)
        set_req0($urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom, $urandom, $urandom);
      if (acc1 || !bus.req1_valid)
        set_req1($urandom_range(0, 1), 5'($urandom_range(0, 5)), $urandom, $urandom, $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      model_pre();
      n_cmp++;
      if (bus.req0_ready !== (e_gnt && !e_id) || bus.req1_ready !== (e_gnt && e_id)) begin
        n_err++; $display("FAIL rnd_ready%0d: got %b%b want %b%b", i, bus.req0_ready,
                          bus.req1_ready, e_gnt && !e_id, e_gnt && e_id);
      end
      n_cmp++;
      if (bus.alu_op !== e_op || bus.alu_a !== e_a || bus.alu_b !== e_b || bus.alu_pc !== e_pc) begin
        n_err++; $display("FAIL rnd_alu%0d: got op=%0h a=%h want op=%0h a=%h", i,
                          bus.alu_op, bus.alu_a, e_op, e_a);
      end
      acc0 = e_gnt && !e_id;
      acc1 = e_gnt && e_id;
      step();
      n_cmp++;
      if (bus.resp_valid !== m_full ||
          (m_full && (bus.resp_c !== m_c || bus.resp_id !== m_id || bus.resp_zero !== m_zero))) begin
        n_err++; $display("FAIL rnd_resp%0d: got v=%b c=%h id=%b z=%b want v=%b c=%h id=%b z=%b", i,
                          bus.resp_valid, bus.resp_c, bus.resp_id, bus.resp_zero,
                          m_full, m_c, m_id, m_zero);
      end
      n_cmp++;
      if (bus.gnt_cnt0 !== CW'(m_cnt0) || bus.gnt_cnt1 !== CW'(m_cnt1)) begin
        n_err++; $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d/%0d", i,
                          bus.gnt_cnt0, bus.gnt_cnt1, m_cnt0, m_cnt1);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.resp_ready = 1'b0;
    set_req0(0, '0, '0, '0, '0);
    set_req1(0, '0, '0, '0, '0);
    test_reset();
    test_alternate();
    test_backpressure();
    test_drain();
    test_saturation();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
